// File: rtl/mult_input_conditioner.sv
// Key synchronize/debounce/press-detect and switch synchronizer feeding the shift-add multiplier.
// Build option: define RUN_QUEUE_EN to hold one Run press made while busy and launch it when busy drops.
module mult_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SW_WIDTH        = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run_raw,
    input  logic                ClearA_LoadB_raw,
    input  logic [SW_WIDTH-1:0] SW,
    input  logic                busy,
    output logic                execute,
    output logic                clearA_loadB,
    output logic [SW_WIDTH-1:0] S_sync,
    output logic [SW_WIDTH-1:0] mand,
    output logic                run_dropped
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // index 0 = Run, index 1 = ClearA_LoadB; levels are active-low (0 = pressed)
    logic [1:0]       rawKeys;
    logic [1:0]       keyMeta;
    logic [1:0]       keySync;
    logic [1:0]       keyStable;
    logic [1:0]       keyStableDly;
    logic [CNT_W-1:0] keyCnt [2];

    logic [SW_WIDTH-1:0] swMeta;
    logic                runEvent;
    logic                clrEvent;

    assign rawKeys = {ClearA_LoadB_raw, Run_raw};

    // Stable level resets to "pressed" so a key held through reset never yields a press.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            keyMeta      <= 2'b11;
            keySync      <= 2'b11;
            keyStable    <= 2'b00;
            keyStableDly <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                keyCnt[i] <= '0;
            end
        end else begin
            keyMeta      <= rawKeys;
            keySync      <= keyMeta;
            keyStableDly <= keyStable;
            for (int i = 0; i < 2; i++) begin
                if (keySync[i] == keyStable[i]) begin
                    keyCnt[i] <= '0;
                end else if (keyCnt[i] == CNT_LAST) begin
                    keyStable[i] <= keySync[i];
                    keyCnt[i]    <= '0;
                end else begin
                    keyCnt[i] <= keyCnt[i] + 1'b1;
                end
            end
        end
    end

    assign runEvent = keyStableDly[0] & ~keyStable[0];
    assign clrEvent = keyStableDly[1] & ~keyStable[1];

`ifdef RUN_QUEUE_EN
    logic runPending;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            swMeta       <= '0;
            S_sync       <= '0;
            mand         <= '0;
            execute      <= 1'b0;
            clearA_loadB <= 1'b0;
            run_dropped  <= 1'b0;
            runPending   <= 1'b0;
        end else begin
            swMeta       <= SW;
            S_sync       <= swMeta;
            execute      <= 1'b0;
            clearA_loadB <= 1'b0;
            if (clrEvent) begin
                clearA_loadB <= 1'b1;
                run_dropped  <= 1'b0;
                runPending   <= 1'b0;
            end else if (runEvent) begin
                if (runPending) begin
                    run_dropped <= 1'b1;
                end else if (busy || execute) begin
                    runPending <= 1'b1;
                end else begin
                    execute <= 1'b1;
                    mand    <= S_sync;
                end
            end else if (runPending && !busy && !execute) begin
                // held press launches on the first idle cycle, using the switches of that cycle
                execute    <= 1'b1;
                mand       <= S_sync;
                runPending <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            swMeta       <= '0;
            S_sync       <= '0;
            mand         <= '0;
            execute      <= 1'b0;
            clearA_loadB <= 1'b0;
            run_dropped  <= 1'b0;
        end else begin
            swMeta       <= SW;
            S_sync       <= swMeta;
            execute      <= 1'b0;
            clearA_loadB <= 1'b0;
            // a simultaneous Run is discarded, and the clear wins over its drop flag
            if (clrEvent) begin
                clearA_loadB <= 1'b1;
                run_dropped  <= 1'b0;
            end else if (runEvent) begin
                if (!busy) begin
                    execute <= 1'b1;
                    mand    <= S_sync;
                end else begin
                    run_dropped <= 1'b1;
                end
            end
        end
    end
`endif

endmodule
